// File: rtl/dwa_element_selector.sv
// rtl/dwa_element_selector.sv - data-weighted-averaging unit-element selector with LFSR pointer dither
module dwa_element_selector #(
  parameter int         CODE_WIDTH = 3,
  parameter int         NUM_ELEM   = 7,
  parameter logic [7:0] LFSR_INIT  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  input  logic                  rand_en,
  input  logic                  ptr_clr,
  output logic [NUM_ELEM-1:0]   en_out,
  output logic                  out_valid,
  output logic [CODE_WIDTH-1:0] ptr_out
);

  // Two extra bits hold start + code + dither (up to 2*NUM_ELEM) without overflow.
  localparam int SW = CODE_WIDTH + 2;
  localparam logic [SW-1:0] N_W = SW'(NUM_ELEM);

  logic [CODE_WIDTH-1:0] ptr;
  logic [7:0]            lfsr;

  logic [SW-1:0]         code_sat;
  logic [SW-1:0]         start;
  logic                  dither;
  logic [SW-1:0]         sum_raw;
  logic [SW-1:0]         sum_mod1;
  logic [SW-1:0]         sum_mod2;
  logic [NUM_ELEM-1:0]   en_next;
  logic [CODE_WIDTH-1:0] ptr_next;
  logic [7:0]            lfsr_next;

  // Element i is on when its distance ahead of the start pointer, around the ring, is below code.
  function automatic logic window_hit(input logic [SW-1:0] idx,
                                      input logic [SW-1:0] s,
                                      input logic [SW-1:0] code);
    logic [SW-1:0] offset;
    if (idx >= s) begin
      offset = idx - s;
    end else begin
      offset = idx + N_W - s;
    end
    return offset < code;
  endfunction

  // Saturate the code, pick the start element and build the rotated thermometer mask.
  always_comb begin
    code_sat = {2'b00, code_in};
    if (code_sat > N_W) begin
      code_sat = N_W;
    end
    start = ptr_clr ? '0 : {2'b00, ptr};
    en_next = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      en_next[i] = window_hit(SW'(i), start, code_sat);
    end
  end

  // Next pointer: dither comes from the pre-advance LFSR bit; two conditional subtracts bound the sum.
  always_comb begin
    dither   = rand_en & lfsr[0];
    sum_raw  = start + code_sat + {{(SW-1){1'b0}}, dither};
    sum_mod1 = (sum_raw  >= N_W) ? (sum_raw  - N_W) : sum_raw;
    sum_mod2 = (sum_mod1 >= N_W) ? (sum_mod1 - N_W) : sum_mod1;
    ptr_next = sum_mod2[CODE_WIDTH-1:0];
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5]};
  end

  // Register outputs, pointer and LFSR; everything holds when no sample is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      lfsr      <= LFSR_INIT;
    end else begin
      out_valid <= code_valid;
      if (code_valid) begin
        en_out <= en_next;
        ptr    <= ptr_next;
        lfsr   <= lfsr_next;
      end
    end
  end

  assign ptr_out = ptr;

endmodule

// File: doc/dwa_element_selector.md
DWA_ELEMENT_SELECTOR -- requirements
Module: dwa_element_selector

Interface
REQ-001 The block SHALL have parameter CODE_WIDTH, default 3, giving the width of the quantizer code input.
REQ-002 The block SHALL have parameter NUM_ELEM, default 7 ((1<<CODE_WIDTH)-1), giving the number of unit DAC elements driven.
REQ-003 The block SHALL have parameter LFSR_INIT, default 8'hFF, giving the reset seed of the internal 8-bit LFSR.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 code_in  input  CODE_WIDTH  unsigned quantizer level 0..NUM_ELEM.
REQ-007 code_valid  input  1  code_in is a new sample this cycle.
REQ-008 rand_en  input  1  enables LFSR pointer-skip dither.
REQ-009 ptr_clr  input  1  forces the rotation pointer to 0 for the current accepted sample.
REQ-010 en_out  output  NUM_ELEM  registered unit-element enables, bit i drives element i.
REQ-011 out_valid  output  1  en_out updated this cycle from an accepted sample.
REQ-012 ptr_out  output  CODE_WIDTH  current rotation pointer (next sample's start element).

Function
REQ-013 A sample SHALL be accepted on every rising edge where code_valid=1 and rst=0; there is no backpressure.
REQ-014 Latency SHALL be exactly 1 cycle: en_out and out_valid reflect the sample accepted on the previous edge.
REQ-015 out_valid SHALL be 1 in the cycle after an accepted sample and 0 otherwise.
REQ-016 With no accepted sample, en_out, ptr_out and LFSR SHALL hold their values.
REQ-017 Start pointer s SHALL be 0 if ptr_clr=1, else the current pointer.
REQ-018 en_out[i] SHALL be 1 exactly for i in {s, s+1, ..., s+code_in-1} mod NUM_ELEM, all other bits 0.
REQ-019 code_in=0 SHALL give en_out all zeros with out_valid=1.
REQ-020 code_in=NUM_ELEM SHALL give en_out all ones.
REQ-021 code_in>NUM_ELEM (only possible for non-default widths) SHALL saturate to NUM_ELEM.
REQ-022 Next pointer SHALL be (s + code_in + d) mod NUM_ELEM, where d = rand_en & lfsr[0] sampled before the LFSR update.
REQ-023 Modulo reduction SHALL handle sums up to 2*NUM_ELEM (conditional subtract, applied up to twice); pointer SHALL never leave 0..NUM_ELEM-1.
REQ-024 The LFSR SHALL advance once per accepted sample, regardless of rand_en: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]}.
REQ-025 ptr_clr without code_valid SHALL have no effect.
REQ-026 rand_en changes SHALL take effect on the next accepted sample only; a sample is never partially dithered.

Reset
REQ-027 While rst=1: en_out=0, out_valid=0, ptr_out=0, lfsr=LFSR_INIT; rst overrides code_valid and ptr_clr.
REQ-028 Reset asserted mid-stream SHALL discard the sample presented in that cycle; the first sample after release starts at pointer 0.

Verification
REQ-029 Rotation/wrap: rst, rand_en=0, codes 3,3,3 -> en_out 7'b0000111, 7'b0111000, 7'b1000011; ptr_out 3, 6, 2.
REQ-030 Extremes: from ptr 2, code 7 -> en_out 7'b1111111, ptr stays 2; then code 0 -> en_out 0, out_valid=1, ptr stays 2.
REQ-031 Gaps: code 2, one idle cycle, code 1 -> out_valid 1,0,1; en_out holds 7'b0000011 through the gap, then 7'b0000100.
REQ-032 ptr_clr: pointer at 5, code 4 with ptr_clr=1 -> en_out 7'b0001111, ptr_out 4.
REQ-033 Dither: after rst, rand_en=1, code 2 -> en_out 7'b0000011, ptr_out 3 (lfsr[0]=1), lfsr 8'hFE; next code 2 -> en_out 7'b0011000, ptr_out 5.
REQ-034 Reset mid-stream: code 3 then rst=1 with code_valid=1 -> next cycle all outputs 0, lfsr 8'hFF; post-release code 1 -> en_out 7'b0000001.
